// File: rtl/clkgen_lock_seq.sv
// ---------------------------------------------------------------------------
// clkgen_lock_seq
//   Bring-up and supervision sequencer for the CLKGEN_MMCM clock generator.
//   It pulses the MMCM reset, waits for LOCKED, requires lock to be stable
//   for a fixed window, then releases the downstream system reset. A timeout
//   or a lock drop before release counts as a failed attempt and the whole
//   sequence is retried. Too many consecutive failed attempts end in a
//   sticky hard failure. A lock drop while running restarts the sequence
//   but is not counted as a failed attempt.
//   The block runs from the free-running board oscillator, so it never
//   depends on the clocks it supervises.
//
// Ports
//   CLK          in   board oscillator clock
//   RST          in   synchronous, active-high reset
//   MMCM_LOCKED  in   MMCM lock flag, asynchronous to CLK
//   MMCM_RST     out  active-high MMCM reset
//   SYS_RST      out  active-high reset for logic on the MMCM clocks
//   READY        out  high only while running with a stable lock
//   FAIL         out  sticky hard-failure flag
//   LOSS         out  one-cycle pulse when lock is lost while running
//   RETRY_CNT    out  total retries since RST, saturating at 15
// ---------------------------------------------------------------------------
module clkgen_lock_seq #(
  parameter int RST_PULSE_CYC    = 16,
  parameter int LOCK_TIMEOUT_CYC = 100000,
  parameter int LOCK_STABLE_CYC  = 1024,
  parameter int MAX_RETRY        = 7,
  parameter int CNT_W            = 20
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       MMCM_LOCKED,
  output logic       MMCM_RST,
  output logic       SYS_RST,
  output logic       READY,
  output logic       FAIL,
  output logic       LOSS,
  output logic [3:0] RETRY_CNT
);

  localparam int FCNT_W = $clog2(MAX_RETRY + 1) + 1;

  localparam logic [CNT_W-1:0]  RST_LAST    = CNT_W'(RST_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0]  STABLE_LAST = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX     = '1;
  localparam logic [FCNT_W-1:0] FCNT_LAST   = FCNT_W'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_RST,
    S_WAIT,
    S_STAB,
    S_RUN,
    S_FAIL
  } state_t;

  state_t            state;
  state_t            state_d;
  logic [CNT_W-1:0]  cnt;
  logic [FCNT_W-1:0] fcnt;
  logic              lk_s1;
  logic              lk_s;
  logic              fail_evt;
  logic              loss_evt;
  logic              retry_evt;
  logic              mmcm_rst_d;
  logic              sys_rst_d;
  logic              ready_d;
  logic              fail_d;

  // Two-flop synchroniser for the asynchronous lock flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      lk_s1 <= 1'b0;
      lk_s  <= 1'b0;
    end else begin
      lk_s1 <= MMCM_LOCKED;
      lk_s  <= lk_s1;
    end
  end

  // State register, shared cycle counter and consecutive-failure counter.
  // The counter restarts on every state change and saturates instead of
  // wrapping, so the RUN and FAIL states can sit in place indefinitely.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_RST;
      cnt   <= '0;
      fcnt  <= '0;
    end else begin
      state <= state_d;
      if (state_d != state) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CNT_W'(1);
      end
      if (state == S_RUN) begin
        fcnt <= '0;
      end else if (fail_evt && (fcnt != FCNT_LAST)) begin
        fcnt <= fcnt + FCNT_W'(1);
      end
    end
  end

  // Output registers: levels follow the current state, so they appear one
  // cycle after the state is entered.
  always_ff @(posedge CLK) begin
    if (RST) begin
      MMCM_RST  <= 1'b1;
      SYS_RST   <= 1'b1;
      READY     <= 1'b0;
      FAIL      <= 1'b0;
      LOSS      <= 1'b0;
      RETRY_CNT <= 4'd0;
    end else begin
      MMCM_RST <= mmcm_rst_d;
      SYS_RST  <= sys_rst_d;
      READY    <= ready_d;
      FAIL     <= fail_d;
      LOSS     <= loss_evt;
      if (retry_evt && (RETRY_CNT != 4'hF)) begin
        RETRY_CNT <= RETRY_CNT + 4'd1;
      end
    end
  end

  // Next-state logic. Lock is tested before the timeout in S_WAIT so a lock
  // arriving on the final wait cycle still counts as success.
  always_comb begin
    state_d    = state;
    fail_evt   = 1'b0;
    loss_evt   = 1'b0;
    mmcm_rst_d = 1'b0;
    sys_rst_d  = 1'b1;
    ready_d    = 1'b0;
    fail_d     = 1'b0;

    case (state)
      S_RST: begin
        mmcm_rst_d = 1'b1;
        if (cnt == RST_LAST) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (lk_s) begin
          state_d = S_STAB;
        end else if (cnt == TIMEOUT_LAST) begin
          fail_evt = 1'b1;
        end
      end
      S_STAB: begin
        if (!lk_s) begin
          fail_evt = 1'b1;
        end else if (cnt == STABLE_LAST) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        sys_rst_d = 1'b0;
        ready_d   = 1'b1;
        if (!lk_s) begin
          loss_evt = 1'b1;
          state_d  = S_RST;
        end
      end
      S_FAIL: begin
        mmcm_rst_d = 1'b1;
        fail_d     = 1'b1;
      end
      default: begin
        state_d = S_RST;
      end
    endcase

    if (fail_evt) begin
      state_d = (fcnt == FCNT_LAST) ? S_FAIL : S_RST;
    end

    retry_evt = loss_evt | (fail_evt & (fcnt != FCNT_LAST));
  end

endmodule

// File: tb/tb_clkgen_lock_seq.sv
module tb_clkgen_lock_seq;

  localparam int RP = 16;
  localparam int TO = 200;
  localparam int ST = 64;
  localparam int MR = 3;

  localparam int P_PULSE  = 0;
  localparam int P_WAIT   = 1;
  localparam int P_STABLE = 2;
  localparam int P_RUN    = 3;
  localparam int P_FAIL   = 4;

  logic       CLK = 1'b0;
  logic       RST;
  logic       MMCM_LOCKED;
  logic       MMCM_RST;
  logic       SYS_RST;
  logic       READY;
  logic       FAIL;
  logic       LOSS;
  logic [3:0] RETRY_CNT;

  int checks   = 0;
  int failures = 0;
  int loss_seen = 0;

  clkgen_lock_seq #(
    .RST_PULSE_CYC   (RP),
    .LOCK_TIMEOUT_CYC(TO),
    .LOCK_STABLE_CYC (ST),
    .MAX_RETRY       (MR),
    .CNT_W           (20)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .MMCM_LOCKED(MMCM_LOCKED),
    .MMCM_RST   (MMCM_RST),
    .SYS_RST    (SYS_RST),
    .READY      (READY),
    .FAIL       (FAIL),
    .LOSS       (LOSS),
    .RETRY_CNT  (RETRY_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic locked);
    RST         = rst;
    MMCM_LOCKED = locked;
  endtask

  // Reference model: lock history delayed two samples, each phase described
  // by its remaining cycle budget, expected outputs reflecting the phase
  // held before the edge.
  int   m_phase;
  int   m_left;
  int   m_fails;
  int   m_retries;
  logic m_h1;
  logic m_h2;
  logic m_lk;
  bit   m_bad;
  bit   model_valid = 1'b0;
  logic e_mr, e_sr, e_rdy, e_fl, e_loss;
  logic [3:0] e_rc;

  always @(posedge CLK) begin
    if (RST === 1'b1) begin
      m_phase = P_PULSE; m_left = RP; m_fails = 0; m_retries = 0;
      m_h1 = 1'b0; m_h2 = 1'b0;
      e_mr = 1'b1; e_sr = 1'b1; e_rdy = 1'b0; e_fl = 1'b0; e_loss = 1'b0; e_rc = 4'd0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      e_mr   = (m_phase == P_PULSE) || (m_phase == P_FAIL);
      e_sr   = (m_phase != P_RUN);
      e_rdy  = (m_phase == P_RUN);
      e_fl   = (m_phase == P_FAIL);
      e_loss = 1'b0;
      m_lk   = m_h2;
      m_bad  = 1'b0;
      case (m_phase)
        P_PULSE: begin
          m_left = m_left - 1;
          if (m_left == 0) begin m_phase = P_WAIT; m_left = TO; end
        end
        P_WAIT: begin
          if (m_lk) begin
            m_phase = P_STABLE; m_left = ST;
          end else begin
            m_left = m_left - 1;
            if (m_left == 0) m_bad = 1'b1;
          end
        end
        P_STABLE: begin
          if (!m_lk) begin
            m_bad = 1'b1;
          end else begin
            m_left = m_left - 1;
            if (m_left == 0) begin m_phase = P_RUN; m_fails = 0; end
          end
        end
        P_RUN: begin
          if (!m_lk) begin
            e_loss = 1'b1;
            if (m_retries < 15) m_retries = m_retries + 1;
            m_phase = P_PULSE; m_left = RP;
          end
        end
        default: ;
      endcase
      if (m_bad) begin
        if (m_fails == MR) begin
          m_phase = P_FAIL;
        end else begin
          m_fails = m_fails + 1;
          if (m_retries < 15) m_retries = m_retries + 1;
          m_phase = P_PULSE; m_left = RP;
        end
      end
      e_rc = 4'(m_retries);
      m_h2 = m_h1;
      m_h1 = MMCM_LOCKED;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge CLK) begin
    if (model_valid) begin
      checkOutput("mdl_MMCM_RST", {31'd0, MMCM_RST}, {31'd0, e_mr});
      checkOutput("mdl_SYS_RST", {31'd0, SYS_RST}, {31'd0, e_sr});
      checkOutput("mdl_READY", {31'd0, READY}, {31'd0, e_rdy});
      checkOutput("mdl_FAIL", {31'd0, FAIL}, {31'd0, e_fl});
      checkOutput("mdl_LOSS", {31'd0, LOSS}, {31'd0, e_loss});
      checkOutput("mdl_RETRY_CNT", {28'd0, RETRY_CNT}, {28'd0, e_rc});
    end
    if (LOSS === 1'b1) loss_seen++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic doReset(input int n, input logic locked);
    applyStimulus(1'b1, locked);
    tick(n);
    applyStimulus(1'b0, locked);
  endtask

  task automatic measureHigh(input bit include_now, output int n);
    n = 0;
    if (!include_now) @(negedge CLK);
    while (MMCM_RST === 1'b1 && n < 1000) begin
      n++;
      @(negedge CLK);
    end
  endtask

  task automatic waitReady(input int budget, input string name);
    int k;
    k = 0;
    while (READY !== 1'b1 && k < budget) begin
      @(negedge CLK);
      k++;
    end
    checkOutput(name, {31'd0, READY}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    int k;
    int ls0;
    int fall_t[$];
    logic prev;

    applyStimulus(1'b1, 1'b0);
    @(negedge CLK);

    // 1. Bring-up
    doReset(4, 1'b0);
    measureHigh(1'b0, n);
    checkOutput("t1_pulse_len", n, 16);
    tick(49);
    MMCM_LOCKED = 1'b1;
    k = 0;
    while (SYS_RST === 1'b1 && k < 300) begin @(negedge CLK); k++; end
    checkOutput("t1_sysrst_latency", k - 1, 67);
    checkOutput("t1_ready", {31'd0, READY}, 32'd1);
    checkOutput("t1_retry", {28'd0, RETRY_CNT}, 32'd0);

    // 4. Lock loss in RUN
    tick(10);
    ls0 = loss_seen;
    MMCM_LOCKED = 1'b0;
    k = 0;
    while (SYS_RST !== 1'b1 && k < 50) begin @(negedge CLK); k++; end
    checkOutput("t4_sysrst_latency", k - 1, 3);
    checkOutput("t4_ready_low", {31'd0, READY}, 32'd0);
    tick(10);
    checkOutput("t4_loss_pulses", loss_seen - ls0, 1);
    checkOutput("t4_retry", {28'd0, RETRY_CNT}, 32'd1);
    MMCM_LOCKED = 1'b1;
    waitReady(400, "t4_rerelease");
    checkOutput("t4_retry_after", {28'd0, RETRY_CNT}, 32'd1);

    // 2. Glitch during stabilisation
    doReset(2, 1'b0);
    measureHigh(1'b0, n);
    checkOutput("t2_first_pulse", n, 16);
    MMCM_LOCKED = 1'b1;
    tick(32);
    MMCM_LOCKED = 1'b0;
    tick(3);
    MMCM_LOCKED = 1'b1;
    k = 0;
    while (MMCM_RST !== 1'b1 && k < 50) begin @(negedge CLK); k++; end
    measureHigh(1'b1, n);
    checkOutput("t2_retry_pulse", n, 16);
    checkOutput("t2_retry", {28'd0, RETRY_CNT}, 32'd1);
    waitReady(400, "t2_release");

    // 3. No lock ever
    doReset(2, 1'b0);
    for (int i = 0; i < 1200; i++) begin
      prev = MMCM_RST;
      @(negedge CLK);
      if (prev === 1'b1 && MMCM_RST === 1'b0) fall_t.push_back(i);
    end
    checkOutput("t3_pulse_count", fall_t.size(), 4);
    for (int i = 1; i < fall_t.size(); i++) begin
      checkOutput("t3_pulse_spacing", fall_t[i] - fall_t[i-1], 216);
    end
    checkOutput("t3_fail", {31'd0, FAIL}, 32'd1);
    checkOutput("t3_mmcm_rst", {31'd0, MMCM_RST}, 32'd1);
    checkOutput("t3_sys_rst", {31'd0, SYS_RST}, 32'd1);
    checkOutput("t3_retry", {28'd0, RETRY_CNT}, 32'd3);

    // 5. RST in FAIL and in stabilisation
    applyStimulus(1'b1, 1'b0);
    @(negedge CLK);
    checkOutput("t5f_mmcm_rst", {31'd0, MMCM_RST}, 32'd1);
    checkOutput("t5f_sys_rst", {31'd0, SYS_RST}, 32'd1);
    checkOutput("t5f_ready", {31'd0, READY}, 32'd0);
    checkOutput("t5f_fail", {31'd0, FAIL}, 32'd0);
    checkOutput("t5f_loss", {31'd0, LOSS}, 32'd0);
    checkOutput("t5f_retry", {28'd0, RETRY_CNT}, 32'd0);
    applyStimulus(1'b0, 1'b0);
    measureHigh(1'b0, n);
    checkOutput("t5f_fresh_pulse", n, 16);
    MMCM_LOCKED = 1'b1;
    tick(12);
    applyStimulus(1'b1, 1'b1);
    @(negedge CLK);
    checkOutput("t5s_mmcm_rst", {31'd0, MMCM_RST}, 32'd1);
    checkOutput("t5s_sys_rst", {31'd0, SYS_RST}, 32'd1);
    applyStimulus(1'b0, 1'b1);
    measureHigh(1'b0, n);
    checkOutput("t5s_fresh_pulse", n, 16);
    waitReady(400, "t5s_release");
    checkOutput("t5s_retry", {28'd0, RETRY_CNT}, 32'd0);

    // 6. Lock on the exact timeout cycle, then one cycle too late
    doReset(2, 1'b0);
    measureHigh(1'b0, n);
    tick(196);
    MMCM_LOCKED = 1'b1;
    waitReady(400, "t6_edge_release");
    checkOutput("t6_edge_retry", {28'd0, RETRY_CNT}, 32'd0);
    doReset(2, 1'b0);
    measureHigh(1'b0, n);
    tick(197);
    MMCM_LOCKED = 1'b1;
    waitReady(600, "t6_late_release");
    checkOutput("t6_late_retry", {28'd0, RETRY_CNT}, 32'd1);

    tick(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
